// File: rtl/nano_ram_arbiter.sv
// rtl/nano_ram_arbiter.sv - CPU/SPI arbiter for the shared single-port data RAM
// Define NANO_RAM_ARB_RR_EN for round-robin; otherwise the CPU (A) has fixed priority.
module nano_ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH  = 5
) (
  input  logic                  CLK,
  input  logic                  NRST,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADD_WIDTH-1:0]  a_add,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADD_WIDTH-1:0]  b_add,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_ack,
  output logic                  ram_we,
  output logic [ADD_WIDTH-1:0]  ram_add,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t                state, state_n;
  logic                  owner_b, owner_b_n;
  logic                  ram_we_n;
  logic [ADD_WIDTH-1:0]  ram_add_n;
  logic [DATA_WIDTH-1:0] ram_din_n;
  logic                  a_ack_n, b_ack_n, busy_n;
  logic [DATA_WIDTH-1:0] a_hold, b_hold;
  logic                  grant_b;

`ifdef NANO_RAM_ARB_RR_EN
  logic last_b, last_b_n;
  // On a tie, the requester that did not win last time gets the RAM.
  assign grant_b = b_req & (~a_req | ~last_b);
`else
  assign grant_b = b_req & ~a_req;
`endif

  always_comb begin
    state_n   = state;
    owner_b_n = owner_b;
    ram_we_n  = 1'b0;
    ram_add_n = ram_add;
    ram_din_n = ram_din;
    a_ack_n   = 1'b0;
    b_ack_n   = 1'b0;
`ifdef NANO_RAM_ARB_RR_EN
    last_b_n  = last_b;
`endif
    case (state)
      IDLE: begin
        if (a_req | b_req) begin
          state_n   = ISSUE;
          owner_b_n = grant_b;
          ram_we_n  = grant_b ? b_we  : a_we;
          ram_add_n = grant_b ? b_add : a_add;
          ram_din_n = grant_b ? b_din : a_din;
`ifdef NANO_RAM_ARB_RR_EN
          last_b_n  = grant_b;
`endif
        end
      end
      ISSUE: begin
        state_n = ACK;
        a_ack_n = ~owner_b;
        b_ack_n = owner_b;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state   <= IDLE;
      owner_b <= 1'b0;
      ram_we  <= 1'b0;
      ram_add <= '0;
      ram_din <= '0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      busy    <= 1'b0;
      a_hold  <= '0;
      b_hold  <= '0;
`ifdef NANO_RAM_ARB_RR_EN
      last_b  <= 1'b1;
`endif
    end else begin
      state   <= state_n;
      owner_b <= owner_b_n;
      ram_we  <= ram_we_n;
      ram_add <= ram_add_n;
      ram_din <= ram_din_n;
      a_ack   <= a_ack_n;
      b_ack   <= b_ack_n;
      busy    <= busy_n;
      // Keep the last delivered word so each port's dout holds outside its ack.
      if (state == ACK && !owner_b) a_hold <= ram_dout;
      if (state == ACK &&  owner_b) b_hold <= ram_dout;
`ifdef NANO_RAM_ARB_RR_EN
      last_b  <= last_b_n;
`endif
    end
  end

  assign a_dout = a_ack ? ram_dout : a_hold;
  assign b_dout = b_ack ? ram_dout : b_hold;

endmodule
